// File: rtl/pc_trace_buffer_pkg.sv
// Shared constants for the PC trace buffer: FSM state encodings and entry sizing.
package pc_trace_buffer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_POST  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // One stored entry is the PC concatenated above the instruction word.
    function automatic int entry_width(input int pc_w, input int instr_w);
        return pc_w + instr_w;
    endfunction

endpackage

// File: rtl/pc_trace_buffer_ram.sv
// Trace storage: DEPTH x WIDTH, synchronous write, asynchronous read, contents never reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_trace_buffer.sv
// Circular PC/instruction trace capture that freezes POST_TRIG entries after a PC match
// and then drains oldest-first over a valid/ready port.
module pc_trace_buffer
    import pc_trace_buffer_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int INSTR_W   = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic                     cap_valid,
    input  logic [PC_W-1:0]          cap_pc,
    input  logic [INSTR_W-1:0]       cap_instr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PC_W-1:0]          rd_pc,
    output logic [INSTR_W-1:0]       rd_instr,
    output logic                     rd_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     wrapped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(PC_W, INSTR_W);

    logic [1:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_post_cnt;
    logic          r_wrapped;

    logic          w_capturing;
    logic          w_wr_en;
    logic          w_trig;
    logic          w_full;
    logic          w_pop;
    logic [EW-1:0] w_rd_data;

    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_wr_en     = cap_valid && !arm && w_capturing;
    assign w_trig      = (r_state == ST_ARMED) && w_wr_en && trig_en && (cap_pc == trig_pc);
    assign w_full      = (r_count == CW'(DEPTH));

    assign rd_valid = (r_state == ST_DONE) && (r_count != '0);
    assign rd_last  = rd_valid && (r_count == CW'(1));
    assign w_pop    = rd_valid && rd_ready;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata ({cap_pc, cap_instr}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign rd_pc    = w_rd_data[EW-1:INSTR_W];
    assign rd_instr = w_rd_data[INSTR_W-1:0];

    // Once full, each new write drops the oldest entry, so rd_ptr tracks wr_ptr - count throughout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
        end else if (arm) begin
            r_state    <= ST_ARMED;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_full) begin
                    r_wrapped <= 1'b1;
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            case (r_state)
                ST_ARMED: begin
                    if (w_trig) begin
                        if (POST_TRIG == 0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state    <= ST_POST;
                            r_post_cnt <= AW'(POST_TRIG);
                        end
                    end
                end
                ST_POST: begin
                    if (w_wr_en) begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == AW'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_count  <= r_count - 1'b1;
                        if (r_count == CW'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count   = r_count;
    assign state   = r_state;
    assign wrapped = r_wrapped;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: scoreboard of captured entries checked against the drain port.
module tb_pc_trace_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        reset_n;
    logic        arm;
    logic        trigEn;
    logic [31:0] trigPc;
    logic        capValid;
    logic [31:0] capPc;
    logic [31:0] capInstr;
    logic        rdReady;

    logic        rdValid,  rdValid0;
    logic [31:0] rdPc,     rdPc0;
    logic [31:0] rdInstr,  rdInstr0;
    logic        rdLast,   rdLast0;
    logic [4:0]  count,    count0;
    logic [1:0]  state,    state0;
    logic        wrapped,  wrapped0;

    int vecCount = 0;
    int errCount = 0;
    entry_t expQ[$];

    pc_trace_buffer #(.PC_W(32), .INSTR_W(32), .DEPTH(16), .POST_TRIG(2)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .trig_en(trigEn), .trig_pc(trigPc),
        .cap_valid(capValid), .cap_pc(capPc), .cap_instr(capInstr),
        .rd_valid(rdValid), .rd_ready(rdReady), .rd_pc(rdPc), .rd_instr(rdInstr),
        .rd_last(rdLast), .count(count), .state(state), .wrapped(wrapped)
    );

    pc_trace_buffer #(.PC_W(32), .INSTR_W(32), .DEPTH(16), .POST_TRIG(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .trig_en(trigEn), .trig_pc(trigPc),
        .cap_valid(capValid), .cap_pc(capPc), .cap_instr(capInstr),
        .rd_valid(rdValid0), .rd_ready(rdReady), .rd_pc(rdPc0), .rd_instr(rdInstr0),
        .rd_last(rdLast0), .count(count0), .state(state0), .wrapped(wrapped0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One capture cycle; entries the buffer should keep go to the scoreboard (depth 16).
    task automatic applyStimulus(input logic [31:0] pc, input bit expectCap);
        entry_t e;
        capValid = 1'b1;
        capPc    = pc;
        capInstr = instrOf(pc);
        tick();
        capValid = 1'b0;
        if (expectCap) begin
            e.pc    = pc;
            e.instr = instrOf(pc);
            expQ.push_back(e);
            if (expQ.size() > 16) void'(expQ.pop_front());
        end
    endtask

    task automatic doArm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        expQ.delete();
    endtask

    task automatic drainCheck(input string tag);
        entry_t e;
        int n;
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            e = expQ.pop_front();
            checkOutput({tag, "_valid"}, 64'(rdValid), 64'd1);
            checkOutput({tag, "_pc"}, 64'(rdPc), 64'(e.pc));
            checkOutput({tag, "_instr"}, 64'(rdInstr), 64'(e.instr));
            checkOutput({tag, "_last"}, 64'(rdLast), 64'(expQ.size() == 0));
            rdReady = 1'b1;
            tick();
            rdReady = 1'b0;
        end
        checkOutput({tag, "_idle"}, 64'(state), 64'd0);
        checkOutput({tag, "_emptyvalid"}, 64'(rdValid), 64'd0);
        checkOutput({tag, "_emptycount"}, 64'(count), 64'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        arm      = 1'b0;
        trigEn   = 1'b0;
        trigPc   = '0;
        capValid = 1'b0;
        capPc    = '0;
        capInstr = '0;
        rdReady  = 1'b0;

        #16;
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) applyStimulus(32'(4 * i), 1'b0);
        checkOutput("noarm_state", 64'(state), 64'd0);
        checkOutput("noarm_count", 64'(count), 64'd0);
        checkOutput("noarm_valid", 64'(rdValid), 64'd0);

        // Capture offered in the arm cycle itself must be dropped.
        trigEn   = 1'b1;
        trigPc   = 32'h8;
        arm      = 1'b1;
        capValid = 1'b1;
        capPc    = 32'h999;
        capInstr = 32'h999;
        tick();
        arm      = 1'b0;
        capValid = 1'b0;
        expQ.delete();
        checkOutput("arm_state", 64'(state), 64'd1);
        checkOutput("arm_count", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) applyStimulus(32'(4 * i), 1'b1);
        checkOutput("trig_post", 64'(state), 64'd2);
        applyStimulus(32'd12, 1'b1);
        checkOutput("post_state", 64'(state), 64'd2);
        applyStimulus(32'd16, 1'b1);
        checkOutput("basic_done", 64'(state), 64'd3);
        checkOutput("basic_count", 64'(count), 64'd5);
        checkOutput("basic_wrapped", 64'(wrapped), 64'd0);
        drainCheck("basic");

        trigPc = 32'(4 * 37);
        doArm();
        for (int i = 0; i < 40; i++) applyStimulus(32'(4 * i), 1'b1);
        checkOutput("wrap_state", 64'(state), 64'd3);
        checkOutput("wrap_count", 64'(count), 64'd16);
        checkOutput("wrap_flag", 64'(wrapped), 64'd1);
        checkOutput("wrap_firstpc", 64'(rdPc), 64'd96);
        applyStimulus(32'h500, 1'b0);
        checkOutput("done_nocap", 64'(count), 64'd16);
        drainCheck("wrap");

        trigPc = 32'h100;
        doArm();
        applyStimulus(32'h100, 1'b1);
        checkOutput("pt0_state", 64'(state0), 64'd3);
        checkOutput("pt0_count", 64'(count0), 64'd1);
        checkOutput("pt0_valid", 64'(rdValid0), 64'd1);
        checkOutput("pt0_last", 64'(rdLast0), 64'd1);
        checkOutput("pt0_pc", 64'(rdPc0), 64'h100);

        // Async reset lands mid-cycle while dut sits in POST; no clock edge in between.
        checkOutput("rst_prepost", 64'(state), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd1 - 64'd1);
        checkOutput("rst_valid0", 64'(rdValid0), 64'd0);
        checkOutput("rst_last0", 64'(rdLast0), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        expQ.delete();

        trigPc = 32'h200;
        doArm();
        applyStimulus(32'h1F0, 1'b1);
        applyStimulus(32'h1F4, 1'b1);
        applyStimulus(32'h200, 1'b1);
        applyStimulus(32'h204, 1'b1);
        applyStimulus(32'h208, 1'b1);
        checkOutput("stall_done", 64'(state), 64'd3);
        checkOutput("stall_count", 64'(count), 64'd5);
        tick();
        checkOutput("stall_pc0", 64'(rdPc), 64'(expQ[0].pc));
        checkOutput("stall_instr0", 64'(rdInstr), 64'(expQ[0].instr));
        rdReady = 1'b1;
        tick();
        rdReady = 1'b0;
        void'(expQ.pop_front());
        tick();
        checkOutput("stall_pc1", 64'(rdPc), 64'(expQ[0].pc));
        checkOutput("stall_count1", 64'(count), 64'd4);
        rdReady = 1'b1;
        tick();
        void'(expQ.pop_front());
        checkOutput("stall_count2", 64'(count), 64'd3);
        arm = 1'b1;
        tick();
        arm     = 1'b0;
        rdReady = 1'b0;
        expQ.delete();
        checkOutput("rearm_count", 64'(count), 64'd0);
        checkOutput("rearm_state", 64'(state), 64'd1);
        checkOutput("rearm_valid", 64'(rdValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
